// File: rtl/uart_pkg.sv
// Shared constants for the MMIO UART receiver: register offsets, STATUS bit map and FSM states.
// RX_PARITY exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;
  localparam logic [31:0] DATA_OFS   = 32'h0;
  localparam logic [31:0] STATUS_OFS = 32'h4;

  localparam int STAT_NONEMPTY = 0;
  localparam int STAT_FULL     = 1;
  localparam int STAT_OVERRUN  = 2;
  localparam int STAT_FRAME    = 3;
  localparam int STAT_PARITY   = 4;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    RX_PARITY = 3'd3,
`endif
    RX_STOP   = 3'd4
  } rx_state_e;
endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO: wrapping read/write pointers plus a separate occupancy count.
// When full, a push is accepted only if a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == (AW+1)'(DEPTH));
  assign count     = r_count;
  assign dout      = r_mem[r_rd];
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/uart_rx_mmio.sv
// UART receiver with a two-register MMIO window (DATA, STATUS) and receive FIFO.
// Define UART_RX_PARITY_EN for 8E1 framing with a sticky parity error; default is 8N1.
module uart_rx_mmio
  import uart_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] BASE         = 32'hf0000200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        oe,
  input  logic [31:0] addr,
  input  logic [3:0]  we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  input  logic        rxd,
  output logic        irq
);
  localparam int             CW     = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  C_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  C_HALF = CW'(CLKS_PER_BIT / 2);

  rx_state_e     r_state, w_next;
  logic          r_sync1, r_sync2, r_rx_prev, r_wait_high;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_overrun, r_frame_err;
  logic          w_parity_err, w_par_bad;

  logic w_rx, w_tick, w_start_det;
  logic w_load_half, w_shift, w_par_chk, w_stop_smp, w_push, w_ferr;

  logic        w_hit_data, w_hit_stat, w_wr, w_pop;
  logic        w_empty, w_full;
  logic [7:0]  w_dout;
  logic [$clog2(FIFO_DEPTH):0] w_count;
  logic [31:0] w_status, w_rd_val;

  // Sync flops reset high so a reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= rxd;
      r_sync2   <= r_sync1;
      r_rx_prev <= r_sync2;
    end
  end
  assign w_rx = r_sync2;

  assign w_tick      = (r_state != RX_IDLE) && (r_cnt == '0);
  assign w_start_det = (r_state == RX_IDLE) && !r_wait_high && r_rx_prev && !w_rx;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= RX_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      RX_IDLE:  if (w_start_det) w_next = RX_START;
      RX_START: if (w_tick) w_next = w_rx ? RX_IDLE : RX_DATA;
`ifdef UART_RX_PARITY_EN
      RX_DATA:   if (w_tick && r_bit == 3'd7) w_next = RX_PARITY;
      RX_PARITY: if (w_tick) w_next = RX_STOP;
`else
      RX_DATA:   if (w_tick && r_bit == 3'd7) w_next = RX_STOP;
`endif
      RX_STOP:  if (w_tick) w_next = RX_IDLE;
      default:  w_next = RX_IDLE;
    endcase
  end

  always_comb begin
    w_load_half = 1'b0;
    w_shift     = 1'b0;
    w_par_chk   = 1'b0;
    w_stop_smp  = 1'b0;
    case (r_state)
      RX_IDLE:   w_load_half = w_start_det;
      RX_DATA:   w_shift     = w_tick;
`ifdef UART_RX_PARITY_EN
      RX_PARITY: w_par_chk   = w_tick;
`endif
      RX_STOP:   w_stop_smp  = w_tick;
      default:   ;
    endcase
    w_push = w_stop_smp & w_rx & ~w_par_bad;
    w_ferr = w_stop_smp & ~w_rx;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      if (w_load_half)            r_cnt <= C_HALF;
      else if (r_state != RX_IDLE) r_cnt <= w_tick ? C_FULL : r_cnt - 1'b1;
      if (w_load_half)  r_bit <= '0;
      else if (w_shift) r_bit <= r_bit + 1'b1;
      if (w_shift) r_shift <= {w_rx, r_shift[7:1]};
    end
  end

  // After a bad stop bit (or reset) the line may still be low; hold off start detection until it idles.
  always_ff @(posedge clk) begin
    if (!rst)       r_wait_high <= 1'b1;
    else if (w_ferr) r_wait_high <= 1'b1;
    else if (w_rx)   r_wait_high <= 1'b0;
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_bad, r_parity_err;
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_par_bad    <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      if (w_load_half)    r_par_bad <= 1'b0;
      else if (w_par_chk) r_par_bad <= ^{r_shift, w_rx};
      if (w_hit_stat && w_wr && wdata[STAT_PARITY]) r_parity_err <= 1'b0;
      if (w_par_chk && ^{r_shift, w_rx})             r_parity_err <= 1'b1;
    end
  end
  assign w_par_bad    = r_par_bad;
  assign w_parity_err = r_parity_err;
`else
  assign w_par_bad    = 1'b0;
  assign w_parity_err = 1'b0;
`endif

  uart_rx_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (r_shift),
    .dout  (w_dout),
    .empty (w_empty),
    .full  (w_full),
    .count (w_count)
  );

  assign w_hit_data = oe && (addr == BASE + DATA_OFS);
  assign w_hit_stat = oe && (addr == BASE + STATUS_OFS);
  assign w_wr       = |we;
  assign w_pop      = w_hit_data & ~w_wr & ~w_empty;

  // Set beats clear when a sticky event and its W1C land in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_hit_stat && w_wr && wdata[STAT_OVERRUN]) r_overrun   <= 1'b0;
      if (w_hit_stat && w_wr && wdata[STAT_FRAME])   r_frame_err <= 1'b0;
      if (w_push && w_full && !w_pop)                r_overrun   <= 1'b1;
      if (w_ferr)                                    r_frame_err <= 1'b1;
    end
  end

  always_comb begin
    w_status                = '0;
    w_status[STAT_NONEMPTY] = ~w_empty;
    w_status[STAT_FULL]     = w_full;
    w_status[STAT_OVERRUN]  = r_overrun;
    w_status[STAT_FRAME]    = r_frame_err;
    w_status[STAT_PARITY]   = w_parity_err;
    w_rd_val = '0;
    if (w_hit_data && !w_wr && !w_empty) w_rd_val = {23'b0, 1'b1, w_dout};
    if (w_hit_stat && !w_wr)             w_rd_val = w_status;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ready <= 1'b0;
      rdata <= '0;
    end else begin
      ready <= w_hit_data | w_hit_stat;
      rdata <= w_rd_val;
    end
  end

  assign irq = ~w_empty | r_overrun | r_frame_err | w_parity_err;

  logic w_unused;
  assign w_unused = &{1'b0, wdata, w_count};
endmodule

// File: tb/tb_uart_rx_mmio.sv
// Randomized bench for uart_rx_mmio: serial frames against a queue-based receiver model,
// bus responses checked by a scoreboard monitor. Honors UART_RX_PARITY_EN.
module tb_uart_rx_mmio;
  localparam int          CPB   = 16;
  localparam int          DEPTH = 8;
  localparam logic [31:0] BASE  = 32'hf0000200;

  logic        clk, rst, oe, ready, rxd, irq;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  we;

  uart_rx_mmio #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .BASE(BASE)) dut (
    .clk(clk), .rst(rst), .oe(oe), .addr(addr), .we(we), .wdata(wdata),
    .rdata(rdata), .ready(ready), .rxd(rxd), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    bit          chk;
    int          due;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mq[$];
  bit         m_ovr, m_frm, m_par;
  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] s = '0;
    s[0] = (mq.size() != 0);
    s[1] = (mq.size() == DEPTH);
    s[2] = m_ovr;
    s[3] = m_frm;
    s[4] = m_par;
    return s;
  endfunction

  function automatic logic m_irq();
    return (mq.size() != 0) || m_ovr || m_frm || m_par;
  endfunction

  // Monitor: every response must match the oldest outstanding request, one cycle after it.
  always @(negedge clk) begin
    if (sb.size() != 0 && sb[0].due < cyc) begin
      total++; bad++;
      $display("FAIL missing_ready: no response for request due at cycle %0d", sb[0].due);
      void'(sb.pop_front());
    end
    if (ready) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_ready: ready=1 with no request outstanding (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("resp_cycle", 32'(cyc), 32'(e.due));
        if (e.chk) check("rdata", rdata, e.data);
      end
    end
  end

  task automatic bus(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d,
                     input bit resp, input logic [31:0] exp, input bit chk);
    @(negedge clk);
    addr = a; we = w; wdata = d; oe = 1'b1;
    if (resp) sb.push_back('{exp, chk, cyc + 1});
    @(negedge clk);
    oe = 1'b0; we = '0;
  endtask

  task automatic rd_data();
    logic [31:0] e = '0;
    if (mq.size() != 0) e = {23'b0, 1'b1, mq.pop_front()};
    bus(BASE, 4'h0, 32'h0, 1'b1, e, 1'b1);
  endtask

  task automatic rd_data_lit(input logic [31:0] lit);
    if (mq.size() != 0) void'(mq.pop_front());
    bus(BASE, 4'h0, 32'h0, 1'b1, lit, 1'b1);
  endtask

  task automatic rd_stat();
    bus(BASE + 32'h4, 4'h0, 32'h0, 1'b1, m_status(), 1'b1);
  endtask

  task automatic wr_stat(input logic [31:0] d);
    bus(BASE + 32'h4, 4'hf, d, 1'b1, 32'h0, 1'b0);
    if (d[2]) m_ovr = 1'b0;
    if (d[3]) m_frm = 1'b0;
    if (d[4]) m_par = 1'b0;
  endtask

  task automatic chk_irq();
    @(negedge clk);
    check("irq", {31'b0, irq}, {31'b0, m_irq()});
  endtask

  task automatic unmapped(input logic [31:0] a, input logic [3:0] w);
    bus(a, w, 32'hffff_ffff, 1'b0, 32'h0, 1'b0);
    check("unmapped_ready", {31'b0, ready}, 32'h0);
  endtask

  // One serial frame; the model is updated once the line is idle again.
  task automatic send_frame(input logic [7:0] b, input bit stop, input bit par_ok);
    @(negedge clk);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rxd = par_ok ? ^b : ~^b;
    repeat (CPB) @(negedge clk);
`endif
    rxd = stop;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
    repeat (CPB) @(negedge clk);
`ifdef UART_RX_PARITY_EN
    if (!par_ok) m_par = 1'b1;
`endif
    if (!stop) m_frm = 1'b1;
    if (stop && par_ok) begin
      if (mq.size() < DEPTH) mq.push_back(b);
      else m_ovr = 1'b1;
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; rxd = 1'b1; we = '0; wdata = '0;
    addr = BASE; oe = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'b0, ready}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    oe = 1'b0;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_no_resp", {31'b0, ready}, 32'h0);

    send_frame(8'h41, 1'b1, 1'b1);
    rd_data_lit(32'h141);
    rd_data_lit(32'h0);

    for (int i = 0; i < 9; i++) send_frame(8'(i), 1'b1, 1'b1);
    rd_stat();
    chk_irq();
    for (int i = 0; i < 8; i++) rd_data_lit(32'h100 + 32'(i));
    rd_stat();
    wr_stat(32'h4);
    rd_stat();

    send_frame(8'h55, 1'b0, 1'b1);
    rd_stat();
    chk_irq();
    wr_stat(32'h8);
    rd_stat();
    chk_irq();

    @(negedge clk);
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    rd_stat();
    chk_irq();
    send_frame(8'h3c, 1'b1, 1'b1);
    rd_data();

    unmapped(BASE + 32'h8, 4'h0);
    unmapped(BASE + 32'h10, 4'hf);
    unmapped(BASE + 32'hfc, 4'h0);
    unmapped(BASE - 32'h4, 4'h0);
    bus(BASE, 4'hf, 32'h1ff, 1'b1, 32'h0, 1'b0);
    rd_stat();

    // Reset in the middle of data bit 3.
    @(negedge clk);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rxd = i[0];
      repeat (CPB) @(negedge clk);
    end
    rxd = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    mq.delete(); m_ovr = 1'b0; m_frm = 1'b0; m_par = 1'b0;
    bus(BASE + 32'h4, 4'h0, 32'h0, 1'b1, 32'h0, 1'b1);
    send_frame(8'h5a, 1'b1, 1'b1);
    rd_data_lit(32'h15a);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0);
    rd_stat();
    rd_data_lit(32'h0);
    wr_stat(32'h10);
    send_frame(8'h07, 1'b1, 1'b1);
    rd_data_lit(32'h107);
`endif

    for (int it = 0; it < 30; it++) begin
      logic [7:0] b;
      bit stop, pok;
      int nops;
      b    = 8'($urandom);
      stop = ($urandom_range(0, 9) != 0);
      pok  = 1'b1;
`ifdef UART_RX_PARITY_EN
      pok  = ($urandom_range(0, 9) != 0);
`endif
      send_frame(b, stop, pok);
      nops = $urandom_range(0, 2);
      for (int k = 0; k < nops; k++) begin
        case ($urandom_range(0, 3))
          0:       rd_data();
          1:       rd_stat();
          2:       wr_stat($urandom & 32'h1c);
          default: chk_irq();
        endcase
      end
    end
    rd_stat();
    chk_irq();

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
